// File: rtl/followme_car_clk_pkg.sv
// Shared widths and reset defaults for the fabric clock-enable generator.
package followme_car_clk_pkg;

    localparam int unsigned DIV_W_DEF     = 5;
    localparam int unsigned LOCK_W        = 16;
    localparam int unsigned DIV_RESET_DEF = 3;

    typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/followme_car_clk_div_ch.sv
// One clock-enable channel: period counter, active/pending divisor, CE pulse and 50% toggle.
module followme_car_clk_div_ch
    import followme_car_clk_pkg::*;
#(
    parameter int unsigned DIV_W     = DIV_W_DEF,
    parameter int unsigned DIV_RESET = DIV_RESET_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_in,
    output logic             ce,
    output logic             tgl,
    output logic             pend
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic             terminal;

    assign terminal = (cnt == div_act);

    // cnt never exceeds div_act, so the increment cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= DIV_W'(DIV_RESET);
            div_pend <= DIV_W'(DIV_RESET);
            ce       <= 1'b0;
            tgl      <= 1'b0;
            pend     <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            ce   <= 1'b0;
            tgl  <= 1'b0;
            pend <= 1'b0;
            if (div_we) begin
                div_act <= div_in;
            end else if (pend) begin
                div_act <= div_pend;
            end
        end else if (terminal) begin
            cnt  <= '0;
            ce   <= 1'b1;
            tgl  <= ~tgl;
            pend <= 1'b0;
            if (div_we) begin
                div_act <= div_in;
            end else if (pend) begin
                div_act <= div_pend;
            end
        end else begin
            cnt <= cnt + DIV_W'(1);
            ce  <= 1'b0;
            // Mid-period writes are parked until the boundary; last write wins.
            if (div_we) begin
                div_pend <= div_in;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/followme_car_fab_clk_en_gen.sv
// Multi-channel programmable clock-enable generator with configuration-stable LOCK flag.
module followme_car_fab_clk_en_gen
    import followme_car_clk_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DIV_RESET   = DIV_RESET_DEF,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              FAB_CLK,
    input  logic              FAB_RESET,
    input  logic [NUM_CH-1:0] EN,
    input  logic [NUM_CH-1:0] DIV_WE,
    input  logic [DIV_W-1:0]  DIV_IN,
    output logic [NUM_CH-1:0] CE,
    output logic [NUM_CH-1:0] TGL,
    output logic [NUM_CH-1:0] PEND,
    output logic              LOCK
);

    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_full;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        followme_car_clk_div_ch #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk    (FAB_CLK),
            .rst    (FAB_RESET),
            .en     (EN[i]),
            .div_we (DIV_WE[i]),
            .div_in (DIV_IN),
            .ce     (CE[i]),
            .tgl    (TGL[i]),
            .pend   (PEND[i])
        );
    end

    assign lock_full = (lock_cnt == LOCK_W'(LOCK_CYCLES));

    // Any divisor write restarts the stability window; EN is deliberately ignored.
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            lock_cnt <= '0;
            LOCK     <= 1'b0;
        end else begin
            LOCK <= lock_full;
            if (|DIV_WE) begin
                lock_cnt <= '0;
            end else if (!lock_full) begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end
        end
    end

endmodule
